// File: rtl/sid_mac_scheduler.sv
// Purpose: TDM frame sequencer for the filter; optionally lends idle muladd slots to an auxiliary requester.
// Latency: cycle_o steps one per clock after tick_i; aux grant-to-ack is exactly 2 clocks.
// Backpressure: aux_req_i waits (no grant) until a free TDM cycle; one aux operation in flight at most.
// Build option: define SID_MAC_SCHEDULER_AUX_EN to include the aux arbitration path.
module sid_mac_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  output logic [3:0]  cycle_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        audio_valid_o,
  output logic        audio_chip_o,
  input  logic [31:0] filt_c_i,
  input  logic        filt_s_i,
  input  logic [15:0] filt_a_i,
  input  logic [15:0] filt_b_i,
  input  logic        aux_req_i,
  input  logic [31:0] aux_c_i,
  input  logic        aux_s_i,
  input  logic [15:0] aux_a_i,
  input  logic [15:0] aux_b_i,
  output logic        aux_gnt_o,
  output logic        aux_ack_o,
  output logic [31:0] aux_o,
  output logic [31:0] mac_c_o,
  output logic        mac_s_o,
  output logic [15:0] mac_a_o,
  output logic [15:0] mac_b_o,
  input  logic [31:0] mac_o_i
);

  // Frame counter: waits at 0 for a tick, then runs 1..15 and wraps back to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_o <= 4'd0;
    end else if (cycle_o == 4'd0) begin
      cycle_o <= tick_i ? 4'd1 : 4'd0;
    end else begin
      cycle_o <= cycle_o + 4'd1;
    end
  end

  // Sticky flag for a tick that lands inside a running frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (tick_i && (cycle_o != 4'd0)) begin
      overrun_o <= 1'b1;
    end
  end

  assign busy_o        = (cycle_o != 4'd0);
  assign audio_valid_o = (cycle_o == 4'd9) || (cycle_o == 4'd14);
  assign audio_chip_o  = (cycle_o == 4'd14);

`ifdef SID_MAC_SCHEDULER_AUX_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } aux_state_t;

  aux_state_t  state;
  aux_state_t  state_nxt;
  logic        slot_free;
  logic        gnt;
  logic [31:0] cap_c;
  logic        cap_s;
  logic [15:0] cap_a;
  logic [15:0] cap_b;
  logic [31:0] aux_res;

  // A slot is free when the filter neither loads operands nor consumes a result next cycle.
  assign slot_free = cycle_o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd12, 4'd14, 4'd15};

  // Aux FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Aux FSM next state and grant; grant is masked while reset is held.
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rst_n && aux_req_i && slot_free) begin
          gnt       = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture aux operands on the granting edge so the requester may move on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_c <= 32'd0;
      cap_s <= 1'b0;
      cap_a <= 16'd0;
      cap_b <= 16'd0;
    end else if (gnt) begin
      cap_c <= aux_c_i;
      cap_s <= aux_s_i;
      cap_a <= aux_a_i;
      cap_b <= aux_b_i;
    end
  end

  // Latch the shared muladd result at the end of the borrowed cycle; held until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aux_res <= 32'd0;
    end else if (state == S_EXEC) begin
      aux_res <= mac_o_i;
    end
  end

  assign aux_gnt_o = gnt;
  assign aux_ack_o = (state == S_ACK);
  assign aux_o     = aux_res;
  assign mac_c_o   = (state == S_EXEC) ? cap_c : filt_c_i;
  assign mac_s_o   = (state == S_EXEC) ? cap_s : filt_s_i;
  assign mac_a_o   = (state == S_EXEC) ? cap_a : filt_a_i;
  assign mac_b_o   = (state == S_EXEC) ? cap_b : filt_b_i;

`else

  logic unused_aux;
  assign unused_aux = ^{aux_req_i, aux_c_i, aux_s_i, aux_a_i, aux_b_i, mac_o_i};

  assign aux_gnt_o = 1'b0;
  assign aux_ack_o = 1'b0;
  assign aux_o     = 32'd0;
  assign mac_c_o   = filt_c_i;
  assign mac_s_o   = filt_s_i;
  assign mac_a_o   = filt_a_i;
  assign mac_b_o   = filt_b_i;

`endif

endmodule

// File: tb/tb_sid_mac_scheduler.sv
// Purpose: randomized scoreboard bench for sid_mac_scheduler against a time-based reference model.
// Latency: expectations pushed one per clock; monitor pops on the following falling edge.
// Backpressure: aux requests held until the model predicts a grant, occasionally dropped early.
module tb_sid_mac_scheduler;

`ifdef SID_MAC_SCHEDULER_AUX_EN
  localparam bit AUX_EN = 1'b1;
`else
  localparam bit AUX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_i = 1'b0;
  logic [3:0]  cycle_o;
  logic        busy_o, overrun_o, audio_valid_o, audio_chip_o;
  logic [31:0] filt_c_i = '0;
  logic        filt_s_i = 1'b0;
  logic [15:0] filt_a_i = '0, filt_b_i = '0;
  logic        aux_req_i = 1'b0;
  logic [31:0] aux_c_i = '0;
  logic        aux_s_i = 1'b0;
  logic [15:0] aux_a_i = '0, aux_b_i = '0;
  logic        aux_gnt_o, aux_ack_o;
  logic [31:0] aux_o;
  logic [31:0] mac_c_o;
  logic        mac_s_o;
  logic [15:0] mac_a_o, mac_b_o;
  logic [31:0] mac_o_i;

  always #5 clk = ~clk;

  sid_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i),
    .cycle_o(cycle_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .audio_valid_o(audio_valid_o), .audio_chip_o(audio_chip_o),
    .filt_c_i(filt_c_i), .filt_s_i(filt_s_i), .filt_a_i(filt_a_i), .filt_b_i(filt_b_i),
    .aux_req_i(aux_req_i), .aux_c_i(aux_c_i), .aux_s_i(aux_s_i), .aux_a_i(aux_a_i), .aux_b_i(aux_b_i),
    .aux_gnt_o(aux_gnt_o), .aux_ack_o(aux_ack_o), .aux_o(aux_o),
    .mac_c_o(mac_c_o), .mac_s_o(mac_s_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o),
    .mac_o_i(mac_o_i)
  );

  // Behavioural shared muladd: c +- a*b with signed 16-bit operands.
  always_comb begin
    int p;
    p = $signed(mac_a_o) * $signed(mac_b_o);
    mac_o_i = mac_s_o ? (mac_c_o - p) : (mac_c_o + p);
  end

  typedef struct {
    int          cyc;
    bit          ovr, av, ach, gnt, ack;
    logic [31:0] auxo, mc;
    logic        ms;
    logic [15:0] ma, mb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] res_q[$];
  int          nvec = 0;
  int          nbad = 0;

  // Reference model state, expressed in absolute clock indices.
  int          now = 0;
  int          t0 = -1;         // clock index at which cycle 1 is shown
  bit          m_ovr = 1'b0;
  int          exec_at = -10;
  int          ack_at = -10;
  logic [31:0] pend_res = '0, last_aux = '0;
  logic [31:0] cap_c = '0;
  logic        cap_s = 1'b0;
  logic [15:0] cap_a = '0, cap_b = '0;
  bit          known = 1'b0;
  bit          granted = 1'b0;

  logic [31:0] op_c = '0;
  logic        op_s = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;

  function automatic int cur_cyc();
    if (t0 >= 0 && now >= t0 && (now - t0) < 15) return now - t0 + 1;
    return 0;
  endfunction

  function automatic bit is_free(int c);
    return (c <= 3) || (c == 7) || (c == 12) || (c == 14) || (c == 15);
  endfunction

  function automatic logic [31:0] ref_mac(logic [31:0] c, logic s, logic [15:0] a, logic [15:0] b);
    int ai, bi;
    ai = $signed(a);
    bi = $signed(b);
    return s ? c - ai * bi : c + ai * bi;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit rst, input bit tk, input bit rq);
    exp_t e;
    int   cyc;
    bit   g;
    @(posedge clk);
    #1;
    rst_n = rst; tick_i = tk; aux_req_i = rq;
    aux_c_i = op_c; aux_s_i = op_s; aux_a_i = op_a; aux_b_i = op_b;
    filt_c_i = $urandom; filt_s_i = 1'($urandom_range(1)); filt_a_i = 16'($urandom); filt_b_i = 16'($urandom);
    cyc = cur_cyc();
    if (now == ack_at) last_aux = pend_res;
    g = AUX_EN && rst && rq && is_free(cyc) && !(now <= ack_at);
    e.cyc = cyc; e.ovr = m_ovr;
    e.av = (cyc == 9) || (cyc == 14); e.ach = (cyc == 14);
    e.gnt = g; e.ack = (now == ack_at); e.auxo = last_aux;
    if (now == exec_at) begin
      e.mc = cap_c; e.ms = cap_s; e.ma = cap_a; e.mb = cap_b;
    end else begin
      e.mc = filt_c_i; e.ms = filt_s_i; e.ma = filt_a_i; e.mb = filt_b_i;
    end
    if (known) exp_q.push_back(e);
    if (!rst) begin
      t0 = -1; m_ovr = 1'b0; last_aux = '0;
      if (ack_at > now) begin
        ack_at = -10; exec_at = -10;
        if (res_q.size() > 0) void'(res_q.pop_back());
      end
      known = 1'b1;
    end else begin
      if (tk) begin
        if (cyc == 0) t0 = now + 1;
        else m_ovr = 1'b1;
      end
      if (g) begin
        cap_c = op_c; cap_s = op_s; cap_a = op_a; cap_b = op_b;
        exec_at = now + 1; ack_at = now + 2;
        pend_res = ref_mac(op_c, op_s, op_a, op_b);
        res_q.push_back(pend_res);
      end
    end
    granted = g;
    now++;
  endtask

  // Monitor: compare every cycle's outputs, and each ack's result against the grant-time prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle_o", 32'(cycle_o), 32'(e.cyc));
      chk("busy_o", 32'(busy_o), 32'(e.cyc != 0));
      chk("overrun_o", 32'(overrun_o), 32'(e.ovr));
      chk("audio_valid_o", 32'(audio_valid_o), 32'(e.av));
      chk("audio_chip_o", 32'(audio_chip_o), 32'(e.ach));
      chk("aux_gnt_o", 32'(aux_gnt_o), 32'(e.gnt));
      chk("aux_ack_o", 32'(aux_ack_o), 32'(e.ack));
      chk("aux_o", aux_o, e.auxo);
      chk("mac_c_o", mac_c_o, e.mc);
      chk("mac_s_o", 32'(mac_s_o), 32'(e.ms));
      chk("mac_a_o", 32'(mac_a_o), 32'(e.ma));
      chk("mac_b_o", 32'(mac_b_o), 32'(e.mb));
    end
    if (aux_ack_o === 1'b1) begin
      if (res_q.size() == 0) chk("ack_without_grant", 32'(aux_ack_o), 32'd0);
      else chk("ack_result", aux_o, res_q.pop_front());
    end
  end

  initial begin
    bit rq_cur;
    // Reset, then a single clean frame.
    repeat (3) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    step(1, 1, 0);
    repeat (18) step(1, 0, 0);

    // Tick at cycle 8 raises overrun; later tick at idle starts a normal frame.
    step(1, 1, 0);
    for (int i = 0; i < 20; i++) step(1, cur_cyc() == 8, 0);
    step(1, 1, 0);
    repeat (17) step(1, 0, 0);

    // Directed aux op requested at cycle 4: c=100, s=0, a=3, b=-7.
    step(0, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 8 && cur_cyc() != 4; i++) step(1, 0, 0);
    op_c = 32'd100; op_s = 1'b0; op_a = 16'd3; op_b = 16'hFFF9;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1);
      if (granted) break;
    end
    repeat (20) step(1, 0, 0);

    // Request held continuously across several frames.
    op_c = $urandom; op_s = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom);
    for (int i = 0; i < 50; i++) step(1, cur_cyc() == 0, 1);
    repeat (4) step(1, 0, 0);

    // Reset during EXEC aborts the operation.
    op_c = $urandom; op_a = 16'($urandom); op_b = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      if (granted) break;
    end
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);

    // Randomized traffic.
    rq_cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (granted) rq_cur = 1'b0;
      else if (rq_cur) rq_cur = ($urandom_range(9) != 0);
      else if ($urandom_range(2) == 0) begin
        rq_cur = 1'b1;
        op_c = $urandom; op_s = 1'($urandom_range(1));
        op_a = 16'($urandom); op_b = 16'($urandom);
      end
      step($urandom_range(99) >= 2, $urandom_range(9) == 0, rq_cur);
    end
    repeat (5) step(1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("results_drained", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
